// File: rtl/eq_output_serializer.sv
// Scales and saturates a 32-bit equalizer sum to 16 bits, then sends it MSB-first with bclk/fsync.
// Optional macro EQ_SER_DOUBLE_BUF_EN adds a one-word holding register for gapless back-to-back frames.
module eq_output_serializer #(
   parameter int SHIFT   = 3,
   parameter int BIT_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:31] sum_in,
   input  logic        sum_valid,
   output logic        sum_ready,
   output logic        sdata,
   output logic        bclk,
   output logic        fsync,
   output logic        sat_flag,
   output logic        busy
);
   localparam int DW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(BIT_DIV / 2);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t             state, state_n;
   logic [DW-1:0]      div_cnt, div_n;
   logic [3:0]         bit_cnt, bit_n;
   logic [15:0]        sh, sh_n;
   logic               sat_n;
   logic signed [31:0] sum_s, scaled;
   logic [15:0]        in_word, start_word;
   logic               in_sat, start_sat;
   logic               accept, last, start;
   logic               busy_n, ready_n, sdata_n, bclk_n, fsync_n;

`ifdef EQ_SER_DOUBLE_BUF_EN
   logic [15:0] hold, hold_n;
   logic        hold_sat, hold_sat_n;
   logic        hold_vld, hold_vld_n;
`endif

   // Bit 0 of sum_in is the MSB, so a plain positional copy gives the numeric value.
   assign sum_s  = $signed(sum_in);
   assign scaled = sum_s >>> SHIFT;

   always_comb begin
      in_word = 16'h7FFF;
      in_sat  = 1'b1;
      if (scaled > 32'sd32767) begin
         in_word = 16'h7FFF;
      end else if (scaled < -32'sd32768) begin
         in_word = 16'h8000;
      end else begin
         in_word = scaled[15:0];
         in_sat  = 1'b0;
      end
   end

   assign accept = sum_valid && sum_ready;
   assign last   = (state == S_SHIFT) && (bit_cnt == 4'd15) && (div_cnt == DIV_LAST);

   always_comb begin
      state_n    = state;
      div_n      = div_cnt;
      bit_n      = bit_cnt;
      sh_n       = sh;
      sat_n      = sat_flag;
      start      = 1'b0;
      start_word = in_word;
      start_sat  = in_sat;
`ifdef EQ_SER_DOUBLE_BUF_EN
      hold_n     = hold;
      hold_sat_n = hold_sat;
      hold_vld_n = hold_vld;
      // A buffered word always wins the shifter; a fresh accept then refills the buffer.
      if (state == S_IDLE || last) begin
         if (hold_vld) begin
            start      = 1'b1;
            start_word = hold;
            start_sat  = hold_sat;
            hold_vld_n = 1'b0;
         end else if (accept) begin
            start = 1'b1;
         end
      end
      if (accept && !(start && !hold_vld)) begin
         hold_n     = in_word;
         hold_sat_n = in_sat;
         hold_vld_n = 1'b1;
      end
      ready_n = 1'b0;
`else
      start   = (state == S_IDLE) && accept;
      ready_n = 1'b0;
`endif

      if (start) begin
         state_n = S_SHIFT;
         div_n   = '0;
         bit_n   = 4'd0;
         sh_n    = start_word;
         sat_n   = start_sat;
      end else if (last) begin
         state_n = S_IDLE;
         div_n   = '0;
         bit_n   = 4'd0;
         sh_n    = 16'h0000;
         sat_n   = 1'b0;
      end else if (state == S_SHIFT) begin
         if (div_cnt == DIV_LAST) begin
            div_n = '0;
            bit_n = bit_cnt + 4'd1;
            sh_n  = {sh[14:0], 1'b0};
         end else begin
            div_n = div_cnt + DW'(1);
         end
      end

      // Outputs are registered from next-state values so they line up with the counters.
      busy_n  = (state_n == S_SHIFT);
      sdata_n = busy_n && sh_n[15];
      bclk_n  = busy_n && (div_n >= DIV_HALF);
      fsync_n = busy_n && (bit_n == 4'd0);
`ifdef EQ_SER_DOUBLE_BUF_EN
      ready_n = !hold_vld_n;
`else
      ready_n = (state_n == S_IDLE);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         div_cnt   <= '0;
         bit_cnt   <= 4'd0;
         sh        <= 16'h0000;
         sdata     <= 1'b0;
         bclk      <= 1'b0;
         fsync     <= 1'b0;
         sat_flag  <= 1'b0;
         busy      <= 1'b0;
         sum_ready <= 1'b0;
`ifdef EQ_SER_DOUBLE_BUF_EN
         hold      <= 16'h0000;
         hold_sat  <= 1'b0;
         hold_vld  <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         div_cnt   <= div_n;
         bit_cnt   <= bit_n;
         sh        <= sh_n;
         sdata     <= sdata_n;
         bclk      <= bclk_n;
         fsync     <= fsync_n;
         sat_flag  <= sat_n;
         busy      <= busy_n;
         sum_ready <= ready_n;
`ifdef EQ_SER_DOUBLE_BUF_EN
         hold      <= hold_n;
         hold_sat  <= hold_sat_n;
         hold_vld  <= hold_vld_n;
`endif
      end
   end
endmodule

// File: tb/tb_eq_output_serializer.sv
// Bench for eq_output_serializer: directed vector table, mid-frame reset, held-valid stream
// and randomized traffic compared against a floor-division/clamp reference model.
module tb_eq_output_serializer;
   localparam int TB_SHIFT = 3;
`ifdef EQ_SER_DOUBLE_BUF_EN
   localparam logic RDY_BUSY = 1'b1;
   localparam int   FRAME_PERIOD = 64;
`else
   localparam logic RDY_BUSY = 1'b0;
   localparam int   FRAME_PERIOD = 65;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sum_in;
   logic        sum_valid;
   logic        sum_ready, sdata, bclk, fsync, sat_flag, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [15:0] rx_q[$];
   logic        rxs_q[$];
   int          fs_times[$];
   logic [31:0] tx_q[$];
   logic [15:0] exp_q[$];
   logic        exps_q[$];

   eq_output_serializer #(.SHIFT(TB_SHIFT), .BIT_DIV(4)) dut (
      .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid),
      .sum_ready(sum_ready), .sdata(sdata), .bclk(bclk), .fsync(fsync),
      .sat_flag(sat_flag), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Serial receiver: frame starts on fsync rise, bits taken on bclk rise.
   logic        prev_bclk = 1'b0, prev_fsync = 1'b0, in_frame = 1'b0, frame_sat = 1'b0;
   logic [15:0] rx_sh = 16'h0;
   int          rx_bits = 0;
   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         rx_bits  = 0;
      end else begin
         if (fsync && !prev_fsync) begin
            in_frame  = 1'b1;
            rx_bits   = 0;
            frame_sat = sat_flag;
            fs_times.push_back(cyc);
         end
         if (in_frame && bclk && !prev_bclk) begin
            rx_sh = {rx_sh[14:0], sdata};
            rx_bits++;
            if (rx_bits == 16) begin
               rx_q.push_back(rx_sh);
               rxs_q.push_back(frame_sat);
               in_frame = 1'b0;
            end
         end
      end
      prev_bclk  = bclk;
      prev_fsync = fsync;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Reference: floor(x / 2^SHIFT), clamped to the signed 16-bit range.
   function automatic void ref_model(input logic [31:0] x, output logic [15:0] w, output logic s);
      longint v, q, den;
      den = longint'(1) << TB_SHIFT;
      v = longint'($signed(x));
      if (v >= 0) q = v / den;
      else q = -((-v + den - 1) / den);
      if (q > 32767) begin w = 16'h7FFF; s = 1'b1; end
      else if (q < -32768) begin w = 16'h8000; s = 1'b1; end
      else begin w = q[15:0]; s = 1'b0; end
   endfunction

   task automatic send(input logic [31:0] d);
      int n;
      @(negedge clk);
      sum_in = d;
      sum_valid = 1'b1;
      n = 0;
      while (!sum_ready && n < 200) begin @(negedge clk); n++; end
      chk("send_ready", 32'(sum_ready), 32'd1);
      @(posedge clk);
      #1 sum_valid = 1'b0;
   endtask

   task automatic check_frame(input string name, input logic [15:0] w, input logic s);
      int bad;
      logic [5:0] act, expv;
      bad = 0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         act  = {sdata, bclk, fsync, busy, sat_flag, sum_ready};
         expv = {w[15 - c/4], (c % 4) >= 2, c < 4, 1'b1, s, RDY_BUSY};
         if (act !== expv) bad++;
      end
      chk({name, "_shape_bad_cycles"}, bad, 0);
      @(negedge clk);
      chk({name, "_after_frame"}, {26'd0, sdata, bclk, fsync, busy, sat_flag, sum_ready}, 32'd1);
      chk({name, "_rx_count"}, rx_q.size(), 1);
      if (rx_q.size() > 0) begin
         chk({name, "_rx_word"}, {16'd0, rx_q[0]}, {16'd0, w});
         chk({name, "_rx_sat"}, {31'd0, rxs_q[0]}, {31'd0, s});
      end
      rx_q.delete();
      rxs_q.delete();
   endtask

   task automatic run_stream(input bit gaps);
      int idx, guard;
      logic [15:0] w;
      logic s;
      idx = 0;
      guard = 0;
      while (idx < tx_q.size() && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (!gaps || $urandom_range(0, 3) != 0) begin
            sum_valid = 1'b1;
            sum_in = tx_q[idx];
         end else begin
            sum_valid = 1'b0;
            sum_in = $urandom;
         end
         if (sum_valid && sum_ready) begin
            ref_model(tx_q[idx], w, s);
            exp_q.push_back(w);
            exps_q.push_back(s);
            idx++;
         end
      end
      chk("stream_all_accepted", idx, tx_q.size());
      @(negedge clk);
      sum_valid = 1'b0;
      guard = 0;
      while (busy && guard < 2000) begin @(negedge clk); guard++; end
      chk("stream_drained", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("stream_rx_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         chk($sformatf("stream_word%0d", i), {16'd0, rx_q[i]}, {16'd0, exp_q[i]});
         chk($sformatf("stream_sat%0d", i), {31'd0, rxs_q[i]}, {31'd0, exps_q[i]});
      end
   endtask

   typedef struct {
      logic [31:0] din;
      logic [15:0] word;
      logic        sat;
   } vec_t;

   initial begin
      vec_t vt[12];
      logic [31:0] x;
      int v;

      vt[0]  = '{32'h0000_0400, 16'h0080, 1'b0};
      vt[1]  = '{32'h0004_0000, 16'h7FFF, 1'b1};
      vt[2]  = '{32'hFFFB_FFF8, 16'h8000, 1'b1};
      vt[3]  = '{32'hFFFF_FF38, 16'hFFE7, 1'b0};
      vt[4]  = '{32'hFFFF_FFFF, 16'hFFFF, 1'b0};
      vt[5]  = '{32'h0003_FFF8, 16'h7FFF, 1'b0};
      vt[6]  = '{32'hFFFC_0000, 16'h8000, 1'b0};
      vt[7]  = '{32'h0003_FFFF, 16'h7FFF, 1'b0};
      vt[8]  = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
      vt[9]  = '{32'h8000_0000, 16'h8000, 1'b1};
      vt[10] = '{32'hFFFF_FFF9, 16'hFFFF, 1'b0};
      vt[11] = '{32'h0000_0007, 16'h0000, 1'b0};

      rst = 1'b1;
      sum_in = 32'h0;
      sum_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {26'd0, sdata, bclk, fsync, busy, sat_flag, sum_ready}, 32'd0);
      rst = 1'b0;
      chk("ready_before_edge", 32'(sum_ready), 32'd0);
      @(negedge clk);
      chk("ready_after_release", 32'(sum_ready), 32'd1);

      for (int i = 0; i < 12; i++) begin
         send(vt[i].din);
         check_frame($sformatf("vec%0d", i), vt[i].word, vt[i].sat);
      end

      // Abort a frame in bit 7 while sdata and bclk are both high.
      send(32'hFFFF_FF38);
      repeat (31) @(negedge clk);
      chk("midframe_pre", {28'd0, sdata, bclk, fsync, busy}, 32'hD);
      rst = 1'b1;
      @(negedge clk);
      chk("midframe_reset", {26'd0, sdata, bclk, fsync, busy, sat_flag, sum_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midframe_ready", 32'(sum_ready), 32'd1);
      rx_q.delete();
      rxs_q.delete();
      send(32'h0000_0400);
      check_frame("post_reset", 16'h0080, 1'b0);

      // Held valid: three words, frame spacing shows the idle gap (or its absence).
      fs_times.delete();
      tx_q = '{32'h400, 32'h800, 32'hC00};
      exp_q.delete();
      exps_q.delete();
      run_stream(1'b0);
      chk("stream_fsync_count", fs_times.size(), 3);
      if (fs_times.size() == 3) begin
         chk("stream_gap01", fs_times[1] - fs_times[0], FRAME_PERIOD);
         chk("stream_gap12", fs_times[2] - fs_times[1], FRAME_PERIOD);
      end
      rx_q.delete();
      rxs_q.delete();

      // Randomized traffic with random valid gaps.
      tx_q.delete();
      exp_q.delete();
      exps_q.delete();
      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 3))
            0: x = $urandom;
            1: begin v = int'($urandom_range(0, 600000)) - 300000; x = v; end
            2: begin
               v = 262136 + int'($urandom_range(0, 16));
               if ($urandom_range(0, 1) == 1) v = -v;
               x = v;
            end
            default: begin v = int'($urandom_range(0, 64)) - 32; x = v; end
         endcase
         tx_q.push_back(x);
      end
      run_stream(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
